triangle_rasterizer: RTL and testbench
======================================

Name: triangle_rasterizer

Overview:
- Sequential producer for the point-in-triangle edge test.
- Takes three vertices on a START pulse and latches them.
- Scans the bounding box in row-major order, testing one candidate point per cycle.
- Streams every inside point out over a valid/ready handshake, then pulses DONE with the total inside count.
- Sits between the geometry setup logic and the pixel/frame-buffer writer.

Parameters:
- W, 12, coordinate width in bits; coordinates are unsigned.
- ACCEPT_BOTH, 0, 0 = inside only when all three edge values are ≥0; 1 = inside also when all three are ≤0 (either winding).

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  begin a scan; sampled only in IDLE.
- PONTOX1, PONTOY1, PONTOX2, PONTOY2, PONTOX3, PONTOY3  input  W each  vertices; sampled on the cycle START is accepted.
- BUSY  output  1  high from the cycle after START is accepted until DONE.
- OUT_VALID  output  1  OUT_X/OUT_Y hold an inside point.
- OUT_READY  input  1  consumer accepts the point.
- OUT_X, OUT_Y  output  W each  inside point coordinates.
- DONE  output  1  one-cycle pulse after the last bbox point is processed.
- COUNT  output  2W+1  number of inside points emitted in the current/last scan.

Behaviour:
- Reset (async, RST_N=0): state IDLE; BUSY, OUT_VALID, DONE = 0; OUT_X, OUT_Y, COUNT = 0. Asserting reset mid-scan aborts immediately; no further outputs.
- FSM states: IDLE, SETUP, SCAN, HOLD, FINISH.
- IDLE: when START=1, latch the vertices and go to SETUP. START is ignored in every other state.
- SETUP (1 cycle):
  - XMIN/XMAX/YMIN/YMAX = min/max of the vertex coordinates.
  - Cursor = (XMIN, YMIN); COUNT cleared.
  - Edge terms computed for the first point.
- SCAN: each cycle evaluates the cursor point P with three edge values:
  - E(A,B,P) = (PX−BX)*(AY−BY) − (AX−BX)*(PY−BY), for edges (V1,V2), (V2,V3), (V3,V1).
  - Width rules: differences are signed W+1 bits, products signed 2W+2 bits, E signed 2W+3 bits. No truncation is permitted.
  - Incremental (per-step add) or direct evaluation is allowed; results must be bit-identical to the direct formula.
- Inside test: all E ≥ 0, or (ACCEPT_BOTH=1 and all E ≤ 0). Points on an edge (E = 0) are inside.
- Inside point:
  - OUT_X/OUT_Y = P, OUT_VALID = 1 on the next cycle, go to HOLD.
  - COUNT increments on the handshake cycle.
- Outside point: no output; the cursor advances and costs one cycle.
- HOLD: OUT_VALID stays high and OUT_X/OUT_Y stay stable until OUT_VALID & OUT_READY. On the handshake, OUT_VALID drops next cycle unless the next evaluated point is also inside. Back-to-back inside points with OUT_READY held high sustain one point per cycle.
- Cursor advance:
  - x+1 until XMAX, then x = XMIN, y+1.
  - After (XMAX, YMAX) is processed (including its handshake, if it is inside), go to FINISH.
- FINISH: DONE = 1 for one cycle; BUSY = 0 on the same cycle; return to IDLE. COUNT holds until the next START is accepted.
- Degenerate inputs:
  - Coincident vertices give a 1×1 bbox; all E = 0, so one point is emitted.
  - Collinear vertices emit the points exactly on the line, per the formula.
- Latency:
  - START accepted at cycle 0; SETUP at cycle 1; first point evaluated at cycle 2.
  - With no stalls, the scan takes bbox_area cycles, plus one for FINISH.
- Vertex inputs may change freely while BUSY; only the latched copy is used.

Test Plan:
- Vertices (0,0),(2,0),(0,2), OUT_READY=1 → emits (0,0),(1,0),(2,0),(0,1),(1,1),(0,2) in that order; COUNT=6; DONE exactly once, 9 scan cycles after SETUP.
- Reversed winding (0,0),(0,2),(2,0) → ACCEPT_BOTH=0: no outputs, COUNT=0, DONE pulses; ACCEPT_BOTH=1: same 6 points as the first scenario.
- Vertices (10,10),(30,10),(20,30) → (15,15) is emitted (E=100,250,50); (9,15) and (10,11) are never emitted; COUNT matches a software reference model.
- Backpressure: first scenario with OUT_READY toggling pseudo-randomly → identical sequence, no drops or duplicates, OUT_X/OUT_Y stable while OUT_VALID & !OUT_READY.
- Width/limit checks:
  - Vertices (4093,4093),(4095,4093),(4093,4095) → 6 points offset by 4093, no overflow.
  - Vertices (5,5)×3 → single point (5,5), COUNT=1.
- Control edges:
  - RST_N low mid-HOLD → OUT_VALID, BUSY, COUNT = 0 immediately.
  - After release and a new START → clean scan.
  - START pulsed while BUSY → ignored.

Source files
------------

// File: rtl/triangle_rasterizer.sv
// Sequential point-in-triangle rasterizer: scans the vertex bounding box row by row,
// streams every inside point over a valid/ready port and pulses DONE with the count.
module triangle_rasterizer #(
    parameter int W           = 12,
    parameter int ACCEPT_BOTH = 0
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           START,
    input  logic [W-1:0]   PONTOX1,
    input  logic [W-1:0]   PONTOY1,
    input  logic [W-1:0]   PONTOX2,
    input  logic [W-1:0]   PONTOY2,
    input  logic [W-1:0]   PONTOX3,
    input  logic [W-1:0]   PONTOY3,
    output logic           BUSY,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [W-1:0]   OUT_X,
    output logic [W-1:0]   OUT_Y,
    output logic           DONE,
    output logic [2*W:0]   COUNT
);

    localparam int EW = 2*W + 3;
    localparam logic [W-1:0]   ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W:0]   ONE_C   = {{(2*W){1'b0}}, 1'b1};
    localparam logic [2*W:0]   ZERO_C  = {(2*W+1){1'b0}};
    localparam logic [W-1:0]   ZERO_W  = {W{1'b0}};
    localparam logic [EW-1:0]  ZERO_E  = {EW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCAN   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m    = (a < b) ? a : b;
        min3 = (c < m) ? c : m;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m    = (a > b) ? a : b;
        max3 = (c > m) ? c : m;
    endfunction

    // Full-precision edge function; sign-extending before the multiply keeps the
    // two's-complement product exact in 2W+2 bits, and the difference exact in 2W+3.
    function automatic logic [EW-1:0] edge_fn(input logic [W-1:0] ax, input logic [W-1:0] ay,
                                              input logic [W-1:0] bx, input logic [W-1:0] by,
                                              input logic [W-1:0] px, input logic [W-1:0] py);
        logic [W:0]     dpx;
        logic [W:0]     day;
        logic [W:0]     dax;
        logic [W:0]     dpy;
        logic [2*W+1:0] p1;
        logic [2*W+1:0] p2;
        dpx = {1'b0, px} - {1'b0, bx};
        day = {1'b0, ay} - {1'b0, by};
        dax = {1'b0, ax} - {1'b0, bx};
        dpy = {1'b0, py} - {1'b0, by};
        p1  = {{(W+1){dpx[W]}}, dpx} * {{(W+1){day[W]}}, day};
        p2  = {{(W+1){dax[W]}}, dax} * {{(W+1){dpy[W]}}, dpy};
        edge_fn = {p1[2*W+1], p1} - {p2[2*W+1], p2};
    endfunction

    state_t         state_q, state_d;
    logic [W-1:0]   x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
    logic [W-1:0]   x1_d, y1_d, x2_d, y2_d, x3_d, y3_d;
    logic [W-1:0]   xmin_q, xmax_q, ymin_q, ymax_q;
    logic [W-1:0]   xmin_d, xmax_d, ymin_d, ymax_d;
    logic [W-1:0]   cx_q, cy_q, cx_d, cy_d;
    logic           last_q, last_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_x_q, out_y_q, out_x_d, out_y_d;
    logic [2*W:0]   count_q, count_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [EW-1:0]  e12_s, e23_s, e31_s;
    logic           all_nonneg_s, all_nonpos_s;
    logic           inside_s, at_end_s, eval_s;

    assign e12_s = edge_fn(x1_q, y1_q, x2_q, y2_q, cx_q, cy_q);
    assign e23_s = edge_fn(x2_q, y2_q, x3_q, y3_q, cx_q, cy_q);
    assign e31_s = edge_fn(x3_q, y3_q, x1_q, y1_q, cx_q, cy_q);

    assign all_nonneg_s = !e12_s[EW-1] && !e23_s[EW-1] && !e31_s[EW-1];
    assign all_nonpos_s = (e12_s[EW-1] || (e12_s == ZERO_E)) &&
                          (e23_s[EW-1] || (e23_s == ZERO_E)) &&
                          (e31_s[EW-1] || (e31_s == ZERO_E));
    assign inside_s     = all_nonneg_s || ((ACCEPT_BOTH != 0) && all_nonpos_s);
    assign at_end_s     = (cx_q == xmax_q) && (cy_q == ymax_q);

    // A point is evaluated in SCAN, or in HOLD on the handshake cycle so that
    // back-to-back inside points sustain one per cycle.
    assign eval_s = (state_q == ST_SCAN) ||
                    ((state_q == ST_HOLD) && OUT_READY && !last_q);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        x2_d        = x2_q;
        y2_d        = y2_q;
        x3_d        = x3_q;
        y3_d        = y3_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        count_d     = count_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    x1_d    = PONTOX1;
                    y1_d    = PONTOY1;
                    x2_d    = PONTOX2;
                    y2_d    = PONTOY2;
                    x3_d    = PONTOX3;
                    y3_d    = PONTOY3;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                xmin_d  = min3(x1_q, x2_q, x3_q);
                xmax_d  = max3(x1_q, x2_q, x3_q);
                ymin_d  = min3(y1_q, y2_q, y3_q);
                ymax_d  = max3(y1_q, y2_q, y3_q);
                cx_d    = min3(x1_q, x2_q, x3_q);
                cy_d    = min3(y1_q, y2_q, y3_q);
                count_d = ZERO_C;
                last_d  = 1'b0;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                state_d = ST_SCAN;
            end
            ST_HOLD: begin
                if (OUT_READY) begin
                    count_d = count_q + ONE_C;
                    if (last_q) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_FINISH;
                    end else begin
                        state_d     = ST_HOLD;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (eval_s) begin
            if (inside_s) begin
                out_x_d     = cx_q;
                out_y_d     = cy_q;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end else begin
                out_valid_d = 1'b0;
                state_d     = at_end_s ? ST_FINISH : ST_SCAN;
            end
            if (at_end_s) begin
                last_d = 1'b1;
            end else if (cx_q == xmax_q) begin
                cx_d = xmin_q;
                cy_d = cy_q + ONE_W;
            end else begin
                cx_d = cx_q + ONE_W;
            end
        end else begin
            last_d = last_d;
        end

        busy_d = (state_d == ST_SETUP) || (state_d == ST_SCAN) || (state_d == ST_HOLD);
        done_d = (state_d == ST_FINISH);
    end

    // State and datapath registers; reset aborts any scan in progress.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            x1_q        <= ZERO_W;
            y1_q        <= ZERO_W;
            x2_q        <= ZERO_W;
            y2_q        <= ZERO_W;
            x3_q        <= ZERO_W;
            y3_q        <= ZERO_W;
            xmin_q      <= ZERO_W;
            xmax_q      <= ZERO_W;
            ymin_q      <= ZERO_W;
            ymax_q      <= ZERO_W;
            cx_q        <= ZERO_W;
            cy_q        <= ZERO_W;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= ZERO_W;
            out_y_q     <= ZERO_W;
            count_q     <= ZERO_C;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            x2_q        <= x2_d;
            y2_q        <= y2_d;
            x3_q        <= x3_d;
            y3_q        <= y3_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign BUSY      = busy_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_X     = out_x_q;
    assign OUT_Y     = out_y_q;
    assign DONE      = done_q;
    assign COUNT     = count_q;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Randomized bench for triangle_rasterizer: two instances (single winding and
// either winding) checked against a plain-arithmetic point-in-triangle model.
module tb_triangle_rasterizer;

    localparam int W = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, ready;
    logic [W-1:0] vx1, vy1, vx2, vy2, vx3, vy3;
    wire  [1:0]   ov, dn, bs;
    wire  [1:0][W-1:0] ox, oy;
    wire  [1:0][2*W:0] cnt;

    triangle_rasterizer #(.W(W), .ACCEPT_BOTH(0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .START(start),
        .PONTOX1(vx1), .PONTOY1(vy1), .PONTOX2(vx2), .PONTOY2(vy2),
        .PONTOX3(vx3), .PONTOY3(vy3),
        .BUSY(bs[0]), .OUT_VALID(ov[0]), .OUT_READY(ready),
        .OUT_X(ox[0]), .OUT_Y(oy[0]), .DONE(dn[0]), .COUNT(cnt[0]));

    triangle_rasterizer #(.W(W), .ACCEPT_BOTH(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start),
        .PONTOX1(vx1), .PONTOY1(vy1), .PONTOX2(vx2), .PONTOY2(vy2),
        .PONTOX3(vx3), .PONTOY3(vy3),
        .BUSY(bs[1]), .OUT_VALID(ov[1]), .OUT_READY(ready),
        .OUT_X(ox[1]), .OUT_Y(oy[1]), .DONE(dn[1]), .COUNT(cnt[1]));

    int total = 0;
    int bad   = 0;
    int q0[$], q1[$], got0[$], got1[$];
    int exp_n[2], last_in[2], done_cnt[2], done_cyc[2];
    int area;
    int cyc = 0;
    logic [1:0]   stall = 2'b00;
    logic [W-1:0] hx[2], hy[2];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic longint edge_val(int ax, int ay, int bx, int by, int px, int py);
        return longint'(px - bx) * longint'(ay - by) - longint'(ax - bx) * longint'(py - by);
    endfunction

    function automatic bit model_in(int mode, int ax, int ay, int bx, int by,
                                    int cx, int cy, int px, int py);
        longint e1, e2, e3;
        e1 = edge_val(ax, ay, bx, by, px, py);
        e2 = edge_val(bx, by, cx, cy, px, py);
        e3 = edge_val(cx, cy, ax, ay, px, py);
        return (e1 >= 0 && e2 >= 0 && e3 >= 0) ||
               (mode == 1 && e1 <= 0 && e2 <= 0 && e3 <= 0);
    endfunction

    function automatic bit has_pt(int lst[$], int p);
        foreach (lst[i]) if (lst[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic build(int ax, int ay, int bx, int by, int cx, int cy);
        int xmin, xmax, ymin, ymax;
        xmin = ax; if (bx < xmin) xmin = bx; if (cx < xmin) xmin = cx;
        xmax = ax; if (bx > xmax) xmax = bx; if (cx > xmax) xmax = cx;
        ymin = ay; if (by < ymin) ymin = by; if (cy < ymin) ymin = cy;
        ymax = ay; if (by > ymax) ymax = by; if (cy > ymax) ymax = cy;
        q0.delete(); q1.delete(); got0.delete(); got1.delete();
        for (int y = ymin; y <= ymax; y++)
            for (int x = xmin; x <= xmax; x++) begin
                if (model_in(0, ax, ay, bx, by, cx, cy, x, y)) q0.push_back((x << 16) | y);
                if (model_in(1, ax, ay, bx, by, cx, cy, x, y)) q1.push_back((x << 16) | y);
            end
        area       = (xmax - xmin + 1) * (ymax - ymin + 1);
        exp_n[0]   = q0.size();
        exp_n[1]   = q1.size();
        last_in[0] = model_in(0, ax, ay, bx, by, cx, cy, xmax, ymax);
        last_in[1] = model_in(1, ax, ay, bx, by, cx, cy, xmax, ymax);
    endtask

    // Output monitor: scoreboard pop on each handshake, stability while stalled.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            stall = 2'b00;
        end else begin
            for (int d = 0; d < 2; d++) begin
                int pt, e;
                if (stall[d]) begin
                    chk("hold_valid", ov[d], 1);
                    chk("hold_xy", {ox[d], oy[d]}, {hx[d], hy[d]});
                end
                if (dn[d]) begin
                    done_cnt[d]++;
                    if (done_cyc[d] < 0) done_cyc[d] = cyc;
                end
                if (ov[d] && ready) begin
                    pt = (int'(ox[d]) << 16) | int'(oy[d]);
                    if (d == 0) begin
                        chk("pt_expected0", q0.size() > 0, 1);
                        e = (q0.size() > 0) ? q0.pop_front() : -1;
                        got0.push_back(pt);
                    end else begin
                        chk("pt_expected1", q1.size() > 0, 1);
                        e = (q1.size() > 0) ? q1.pop_front() : -1;
                        got1.push_back(pt);
                    end
                    chk("pt_value", pt, e);
                end
                stall[d] = ov[d] && !ready;
                hx[d]    = ox[d];
                hy[d]    = oy[d];
            end
        end
    end

    task automatic run_scan(int ax, int ay, int bx, int by, int cx, int cy, int rmode);
        logic [1:0] bsnow;
        int n;
        build(ax, ay, bx, by, cx, cy);
        done_cnt[0] = 0; done_cnt[1] = 0;
        done_cyc[0] = -1; done_cyc[1] = -1;
        @(posedge clk); #1;
        vx1 = ax[W-1:0]; vy1 = ay[W-1:0]; vx2 = bx[W-1:0];
        vy2 = by[W-1:0]; vx3 = cx[W-1:0]; vy3 = cy[W-1:0];
        start = 1'b1;
        ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        n     = 0;
        @(negedge clk);
        chk("busy_after_start", bs, 2'b11);
        bsnow = bs;
        while (n < 5000 && !(done_cnt[0] > 0 && done_cnt[1] > 0)) begin
            @(posedge clk); #1;
            cyc++;
            n++;
            vx1 = W'($urandom_range(0, 4095)); vy1 = W'($urandom_range(0, 4095));
            vx2 = W'($urandom_range(0, 4095)); vy2 = W'($urandom_range(0, 4095));
            vx3 = W'($urandom_range(0, 4095)); vy3 = W'($urandom_range(0, 4095));
            ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (bsnow == 2'b11) && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            bsnow = bs;
        end
        @(posedge clk); #1;
        start = 1'b0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("done_pulses", done_cnt[d], 1);
            chk("count", cnt[d], exp_n[d]);
            chk("busy_idle", bs[d], 0);
            if (rmode == 0) chk("latency", done_cyc[d], 2 + area + last_in[d]);
        end
        chk("left0", q0.size(), 0);
        chk("left1", q1.size(), 0);
    endtask

    int lit[6];

    initial begin
        int n;
        lit = '{0, 1 << 16, 2 << 16, 1, (1 << 16) | 1, 2};
        rst_n = 1'b1; start = 1'b0; ready = 1'b1;
        vx1 = '0; vy1 = '0; vx2 = '0; vy2 = '0; vx3 = '0; vy3 = '0;
        done_cnt[0] = 0; done_cnt[1] = 0; done_cyc[0] = -1; done_cyc[1] = -1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", ov[d], 0);
            chk("rst_busy", bs[d], 0);
            chk("rst_done", dn[d], 0);
            chk("rst_x", ox[d], 0);
            chk("rst_y", oy[d], 0);
            chk("rst_count", cnt[d], 0);
        end
        rst_n = 1'b1;

        // Model pins from hand-computed values.
        chk("pin_e12", edge_val(10, 10, 30, 10, 15, 15), 100);
        chk("pin_e23", edge_val(30, 10, 20, 30, 15, 15), 250);
        chk("pin_e31", edge_val(20, 30, 10, 10, 15, 15), 50);
        chk("pin_out_9_15", model_in(0, 10, 10, 30, 10, 20, 30, 9, 15), 0);
        chk("pin_out_10_11", model_in(0, 10, 10, 30, 10, 20, 30, 10, 11), 0);
        build(0, 0, 2, 0, 0, 2);
        chk("pin_n", q0.size(), 6);
        for (int i = 0; i < 6; i++) chk("pin_seq", q0[i], lit[i]);

        run_scan(0, 0, 2, 0, 0, 2, 0);
        chk("s1_done_cycle", done_cyc[0], 11);
        chk("s1_n", got0.size(), 6);
        for (int i = 0; i < 6 && i < got0.size(); i++) chk("s1_seq", got0[i], lit[i]);

        run_scan(0, 0, 0, 2, 2, 0, 0);
        chk("rev_count0", cnt[0], 0);
        chk("rev_count1", cnt[1], 6);
        for (int i = 0; i < 6 && i < got1.size(); i++) chk("rev_seq1", got1[i], lit[i]);

        run_scan(10, 10, 30, 10, 20, 30, 1);
        chk("tri_has_15_15", has_pt(got0, (15 << 16) | 15), 1);
        chk("tri_no_9_15", has_pt(got0, (9 << 16) | 15), 0);
        chk("tri_no_10_11", has_pt(got0, (10 << 16) | 11), 0);

        run_scan(0, 0, 2, 0, 0, 2, 1);
        chk("bp_n", got0.size(), 6);
        for (int i = 0; i < 6 && i < got0.size(); i++) chk("bp_seq", got0[i], lit[i]);

        run_scan(4093, 4093, 4095, 4093, 4093, 4095, 0);
        chk("big_n", got0.size(), 6);
        for (int i = 0; i < 6 && i < got0.size(); i++)
            chk("big_seq", got0[i], lit[i] + ((4093 << 16) | 4093));

        run_scan(5, 5, 5, 5, 5, 5, 0);
        chk("pt_count", cnt[0], 1);
        chk("pt_done_cycle", done_cyc[0], 4);
        chk("pt_value_lit", (got0.size() > 0) ? got0[0] : -1, (5 << 16) | 5);

        // Reset while stalled in HOLD.
        build(0, 0, 2, 0, 0, 2);
        @(posedge clk); #1;
        vx1 = 12'd0; vy1 = 12'd0; vx2 = 12'd2; vy2 = 12'd0; vx3 = 12'd0; vy3 = 12'd2;
        start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n = 0;
        while (cnt[0] < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_reach", n < 200, 1);
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", ov[0], 1);
        chk("pre_rst_x", ox[0], 0);
        chk("pre_rst_y", oy[0], 1);
        chk("pre_rst_count", cnt[0], 3);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("mid_rst_valid", ov[d], 0);
            chk("mid_rst_busy", bs[d], 0);
            chk("mid_rst_count", cnt[d], 0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        run_scan(0, 0, 2, 0, 0, 2, 0);
        chk("post_rst_done_cycle", done_cyc[0], 11);

        for (int t = 0; t < 8; t++) begin
            int bx0, by0;
            bx0 = (t < 4) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 4080));
            by0 = (t < 4) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 4080));
            run_scan(bx0 + int'($urandom_range(0, 14)), by0 + int'($urandom_range(0, 14)),
                     bx0 + int'($urandom_range(0, 14)), by0 + int'($urandom_range(0, 14)),
                     bx0 + int'($urandom_range(0, 14)), by0 + int'($urandom_range(0, 14)),
                     t % 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
